// File: rtl/lms_fir_engine_pkg.sv
// Shared widths and output saturation for the 16-tap LMS FIR output stage.
// Combinational helpers only; no latency, no backpressure.
package lms_fir_engine_pkg;

  localparam int TAPS  = 16;
  localparam int DW    = 14;
  localparam int WW    = 32;
  localparam int WFRAC = 28;
  localparam int AW    = 48;
  localparam int PW    = DW + WW;

  localparam logic signed [AW-1:0] SAT_HI = AW'(8191);
  localparam logic signed [AW-1:0] SAT_LO = AW'(-8192);

  function automatic logic signed [DW-1:0] sat14(input logic signed [AW-1:0] v);
    logic signed [DW-1:0] r;
    if (v > SAT_HI)      r = SAT_HI[DW-1:0];
    else if (v < SAT_LO) r = SAT_LO[DW-1:0];
    else                 r = v[DW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/lms_mac_sat.sv
// Signed sample x weight multiply-accumulate, cleared on the first tap, one product per clock.
// acc_next is combinational (current acc + product); acc registers it while en is high.
module lms_mac_sat
  import lms_fir_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 clr,
  input  logic signed [DW-1:0] x,
  input  logic signed [WW-1:0] w,
  output logic signed [AW-1:0] acc_next
);

  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] base;
  logic signed [PW-1:0] prod;
  logic signed [AW:0]   sum;

  assign prod = PW'(x) * PW'(w);
  assign base = clr ? '0 : acc;
  assign sum  = {base[AW-1], base} + {{(AW+1-PW){prod[PW-1]}}, prod};

  // Clamp instead of wrapping so a full-scale window still saturates to the right rail.
  always_comb begin
    acc_next = sum[AW-1:0];
    if (sum[AW] != sum[AW-1])
      acc_next = sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)    acc <= '0;
    else if (en) acc <= acc_next;
  end

endmodule

// File: rtl/lms_fir_engine.sv
// 16-tap LMS FIR estimate/error stage: d/e update on the 16th consecutive enabled edge.
// No backpressure; dropping adap_filter_state discards the partial window.
module lms_fir_engine
  import lms_fir_engine_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 adap_filter_state,
  input  logic signed [DW-1:0] reff_0,
  input  logic signed [DW-1:0] reff_1,
  input  logic signed [DW-1:0] reff_2,
  input  logic signed [DW-1:0] reff_3,
  input  logic signed [DW-1:0] reff_4,
  input  logic signed [DW-1:0] reff_5,
  input  logic signed [DW-1:0] reff_6,
  input  logic signed [DW-1:0] reff_7,
  input  logic signed [DW-1:0] reff_8,
  input  logic signed [DW-1:0] reff_9,
  input  logic signed [DW-1:0] reff_10,
  input  logic signed [DW-1:0] reff_11,
  input  logic signed [DW-1:0] reff_12,
  input  logic signed [DW-1:0] reff_13,
  input  logic signed [DW-1:0] reff_14,
  input  logic signed [DW-1:0] reff_15,
  input  logic signed [DW-1:0] buffer_in_0,
  input  logic signed [DW-1:0] buffer_in_1,
  input  logic signed [DW-1:0] buffer_in_2,
  input  logic signed [DW-1:0] buffer_in_3,
  input  logic signed [DW-1:0] buffer_in_4,
  input  logic signed [DW-1:0] buffer_in_5,
  input  logic signed [DW-1:0] buffer_in_6,
  input  logic signed [DW-1:0] buffer_in_7,
  input  logic signed [DW-1:0] buffer_in_8,
  input  logic signed [DW-1:0] buffer_in_9,
  input  logic signed [DW-1:0] buffer_in_10,
  input  logic signed [DW-1:0] buffer_in_11,
  input  logic signed [DW-1:0] buffer_in_12,
  input  logic signed [DW-1:0] buffer_in_13,
  input  logic signed [DW-1:0] buffer_in_14,
  input  logic signed [DW-1:0] buffer_in_15,
  input  logic signed [DW-1:0] buffer_in_16,
  input  logic signed [WW-1:0] weight_in_0,
  input  logic signed [WW-1:0] weight_in_1,
  input  logic signed [WW-1:0] weight_in_2,
  input  logic signed [WW-1:0] weight_in_3,
  input  logic signed [WW-1:0] weight_in_4,
  input  logic signed [WW-1:0] weight_in_5,
  input  logic signed [WW-1:0] weight_in_6,
  input  logic signed [WW-1:0] weight_in_7,
  input  logic signed [WW-1:0] weight_in_8,
  input  logic signed [WW-1:0] weight_in_9,
  input  logic signed [WW-1:0] weight_in_10,
  input  logic signed [WW-1:0] weight_in_11,
  input  logic signed [WW-1:0] weight_in_12,
  input  logic signed [WW-1:0] weight_in_13,
  input  logic signed [WW-1:0] weight_in_14,
  input  logic signed [WW-1:0] weight_in_15,
  output logic signed [DW-1:0] d,
  output logic signed [DW-1:0] e
);

  logic signed [DW-1:0] reff_arr [TAPS];
  logic signed [WW-1:0] w_arr    [TAPS];
  logic [3:0]           idx;
  logic                 last;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] y;
  logic signed [DW-1:0] d_new;
  logic signed [DW:0]   diff;
  logic signed [DW-1:0] e_new;
  logic                 unused_buffers;

  // Upper buffer taps exist only for port compatibility with the shift-RAM wrapper.
  assign unused_buffers = ^{buffer_in_1, buffer_in_2, buffer_in_3, buffer_in_4,
                            buffer_in_5, buffer_in_6, buffer_in_7, buffer_in_8,
                            buffer_in_9, buffer_in_10, buffer_in_11, buffer_in_12,
                            buffer_in_13, buffer_in_14, buffer_in_15, buffer_in_16};

  assign reff_arr = '{reff_0, reff_1, reff_2, reff_3, reff_4, reff_5, reff_6, reff_7,
                      reff_8, reff_9, reff_10, reff_11, reff_12, reff_13, reff_14, reff_15};
  assign w_arr    = '{weight_in_0, weight_in_1, weight_in_2, weight_in_3,
                      weight_in_4, weight_in_5, weight_in_6, weight_in_7,
                      weight_in_8, weight_in_9, weight_in_10, weight_in_11,
                      weight_in_12, weight_in_13, weight_in_14, weight_in_15};

  assign last = (idx == 4'(TAPS - 1));

  lms_mac_sat u_mac (
    .clk      (clk),
    .rstn     (rstn),
    .en       (adap_filter_state),
    .clr      (idx == 4'd0),
    .x        (reff_arr[idx]),
    .w        (w_arr[idx]),
    .acc_next (acc_next)
  );

  // Arithmetic shift floors toward -inf, dropping the Q4.28 fraction.
  assign y     = acc_next >>> WFRAC;
  assign d_new = sat14(y);
  assign diff  = {buffer_in_0[DW-1], buffer_in_0} - {d_new[DW-1], d_new};
  assign e_new = sat14(AW'(diff));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      idx <= '0;
      d   <= '0;
      e   <= '0;
    end else if (adap_filter_state) begin
      idx <= idx + 4'd1;
      if (last) begin
        d <= d_new;
        e <= e_new;
      end
    end else begin
      idx <= '0;
    end
  end

endmodule

// File: tb/tb_lms_fir_engine.sv
// Directed and randomized windows against an exact-arithmetic reference of the filter rules.
module tb_lms_fir_engine;

  logic               clk = 1'b0;
  logic               rstn;
  logic               en;
  logic signed [13:0] reff [16];
  logic signed [31:0] w    [16];
  logic signed [13:0] buf0;
  logic signed [13:0] bufx;
  logic signed [13:0] d, e;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int exp_d  = 0;
  int exp_e  = 0;

  always #5 clk = ~clk;

  lms_fir_engine dut (
    .clk(clk), .rstn(rstn), .adap_filter_state(en),
    .reff_0(reff[0]),   .reff_1(reff[1]),   .reff_2(reff[2]),   .reff_3(reff[3]),
    .reff_4(reff[4]),   .reff_5(reff[5]),   .reff_6(reff[6]),   .reff_7(reff[7]),
    .reff_8(reff[8]),   .reff_9(reff[9]),   .reff_10(reff[10]), .reff_11(reff[11]),
    .reff_12(reff[12]), .reff_13(reff[13]), .reff_14(reff[14]), .reff_15(reff[15]),
    .buffer_in_0(buf0),
    .buffer_in_1(bufx),  .buffer_in_2(bufx),  .buffer_in_3(bufx),  .buffer_in_4(bufx),
    .buffer_in_5(bufx),  .buffer_in_6(bufx),  .buffer_in_7(bufx),  .buffer_in_8(bufx),
    .buffer_in_9(bufx),  .buffer_in_10(bufx), .buffer_in_11(bufx), .buffer_in_12(bufx),
    .buffer_in_13(bufx), .buffer_in_14(bufx), .buffer_in_15(bufx), .buffer_in_16(bufx),
    .weight_in_0(w[0]),   .weight_in_1(w[1]),   .weight_in_2(w[2]),   .weight_in_3(w[3]),
    .weight_in_4(w[4]),   .weight_in_5(w[5]),   .weight_in_6(w[6]),   .weight_in_7(w[7]),
    .weight_in_8(w[8]),   .weight_in_9(w[9]),   .weight_in_10(w[10]), .weight_in_11(w[11]),
    .weight_in_12(w[12]), .weight_in_13(w[13]), .weight_in_14(w[14]), .weight_in_15(w[15]),
    .d(d), .e(e)
  );

  task automatic check(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic longint clampl(input longint v, input longint lo, input longint hi);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  // Exact dot product with the accumulator held inside its signed 48-bit range,
  // floored to an integer, then clamped to the 14-bit sample range.
  task automatic model();
    longint acc = 0;
    longint amax = (longint'(1) <<< 47) - 1;
    longint amin = -(longint'(1) <<< 47);
    longint y;
    for (int k = 0; k < 16; k++)
      acc = clampl(acc + longint'(w[k]) * longint'(reff[k]), amin, amax);
    y = clampl(acc >>> 28, -8192, 8191);
    exp_d = int'(y);
    exp_e = int'(clampl(longint'(buf0) - y, -8192, 8191));
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 16; k++) begin
      reff[k] = '0;
      w[k]    = '0;
    end
    buf0 = '0;
  endtask

  // Called at a negedge; leaves the caller at the negedge after the 16th enabled edge.
  task automatic run_window(input string tag, input bit keep_en);
    en = 1'b1;
    repeat (15) @(negedge clk);
    check({tag, "_hold15"}, d, exp_d);
    @(negedge clk);
    model();
    check({tag, "_d"}, d, exp_d);
    check({tag, "_e"}, e, exp_e);
    if (!keep_en) en = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    en   = 1'b0;
    bufx = '0;
    clear_inputs();
    repeat (2) @(negedge clk);
    check("reset_d", d, 0);
    check("reset_e", e, 0);
    rstn = 1'b0;
    @(negedge clk);

    w[0] = 32'h1000_0000; reff[0] = 14'sd100; buf0 = 14'sd300;
    run_window("unit", 1'b0);
    check("unit_lit_d", d, 100);
    check("unit_lit_e", e, 200);
    @(negedge clk);

    clear_inputs(); buf0 = -14'sd1234;
    run_window("zero_w", 1'b0);
    check("zero_w_lit_e", e, -1234);
    @(negedge clk);

    clear_inputs();
    w[3] = 32'hF800_0000; reff[3] = -14'sd200;
    w[7] = 32'h0800_0000; reff[7] = 14'sd51;
    run_window("negfrac", 1'b0);
    check("negfrac_lit_d", d, 125);
    check("negfrac_lit_e", e, -125);
    @(negedge clk);

    for (int k = 0; k < 16; k++) begin
      w[k] = 32'h7000_0000; reff[k] = 14'sd8191;
    end
    buf0 = -14'sd8192;
    run_window("sat_pos", 1'b0);
    check("sat_pos_lit_d", d, 8191);
    check("sat_pos_lit_e", e, -8192);
    @(negedge clk);
    for (int k = 0; k < 16; k++) reff[k] = -14'sd8191;
    run_window("sat_neg", 1'b0);
    check("sat_neg_lit_d", d, -8192);
    @(negedge clk);

    // Aborted window must leave outputs untouched and leave no residue.
    clear_inputs(); w[5] = 32'h2000_0000; reff[5] = 14'sd1000; buf0 = 14'sd77;
    en = 1'b1;
    repeat (8) @(negedge clk);
    en = 1'b0;
    check("abort_hold_d", d, exp_d);
    check("abort_hold_e", e, exp_e);
    @(negedge clk);
    w[5] = 32'h1000_0000; reff[5] = 14'sd40; buf0 = 14'sd10;
    run_window("after_abort", 1'b0);
    check("after_abort_lit_d", d, 40);
    @(negedge clk);

    // Back-to-back windows with enable held high across the boundary.
    clear_inputs(); w[15] = 32'h1000_0000; reff[15] = -14'sd321; buf0 = 14'sd5;
    run_window("b2b_first", 1'b1);
    reff[15] = 14'sd654; buf0 = -14'sd6;
    run_window("b2b_second", 1'b0);
    @(negedge clk);

    // Reset in the middle of a window.
    clear_inputs(); w[2] = 32'h3000_0000; reff[2] = 14'sd500; buf0 = 14'sd2000;
    en = 1'b1;
    repeat (10) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("midreset_d", d, 0);
    check("midreset_e", e, 0);
    exp_d = 0; exp_e = 0;
    en = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    run_window("post_reset", 1'b0);
    check("post_reset_lit_d", d, 1500);
    @(negedge clk);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 16; k++) begin
        reff[k] = 14'($urandom_range(0, 16383));
        if ($urandom_range(0, 1) == 0) w[k] = 32'($urandom);
        else w[k] = 32'(int'($urandom_range(0, 1 << 25)) - (1 << 24));
      end
      buf0 = 14'($urandom_range(0, 16383));
      run_window($sformatf("rand%0d", t), 1'b0);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
